// File: rtl/native_bus_fabric.sv
// native_bus_fabric: single-master, N-slave router for the picorv32 native memory bus,
// with unmapped-address and slave-timeout errors. BUS_ERR_CAPTURE_EN adds err_addr/err_count capture.
module native_bus_fabric #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = {32'h8000_0010, 32'h8000_0008,
                                                          32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = {32'hFFFF_FFF0, 32'hFFFF_FFF8,
                                                          32'hFFFF_FFFF, 32'hFFFE_0000},
  parameter int unsigned                TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      slv_valid,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  input  logic [NUM_SLAVES*32-1:0]   slv_rdata,
  output logic [31:0]                slv_addr,
  output logic [31:0]                slv_wdata,
  output logic [3:0]                 slv_wstrb,
  output logic                       bus_err,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count
);

  localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   hit_idx, idx_q;
  logic               hit_any;
  logic [15:0]        cnt_q;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               do_accept, do_miss, do_done, do_timeout;

  // Lowest-index match wins when map entries overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_any && ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ready = slv_ready[idx_q];
  assign sel_rdata = slv_rdata[32*idx_q +: 32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_accept  = 1'b0;
    do_miss    = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (hit_any) begin
            do_accept = 1'b1;
            state_nxt = ACCESS;
          end else begin
            do_miss   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        // A ready arriving on the last allowed cycle beats the timeout.
        if (sel_ready) begin
          do_done   = 1'b1;
          state_nxt = RESP;
        end else if (cnt_q == TO_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      slv_valid <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      cnt_q     <= (state == ACCESS) ? cnt_q + 16'd1 : '0;
      mem_ready <= do_miss | do_done | do_timeout;
      bus_err   <= do_miss | do_timeout;
      if (do_accept) begin
        idx_q     <= hit_idx;
        slv_addr  <= mem_addr;
        slv_wdata <= mem_wdata;
        slv_wstrb <= mem_wstrb;
        slv_valid <= NUM_SLAVES'(1) << hit_idx;
      end else if (do_done || do_timeout) begin
        slv_valid <= '0;
      end
      if (do_done)
        mem_rdata <= sel_rdata;
      else if (do_miss || do_timeout)
        mem_rdata <= ERR_DATA;
    end
  end

`ifdef BUS_ERR_CAPTURE_EN
  logic [31:0] err_addr_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      // A miss never latched the address, so take it from the core side.
      if (do_miss)
        err_addr_q <= mem_addr;
      else if (do_timeout)
        err_addr_q <= slv_addr;
      if ((do_miss || do_timeout) && (err_count_q != 8'hFF))
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
`else
  assign err_addr  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_native_bus_fabric.sv
// Directed self-checking bench for native_bus_fabric: decode, wait states, miss, timeout,
// overlapping map priority and asynchronous reset abort.
module tb_native_bus_fabric;

`ifdef BUS_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         mem_valid, mem_ready, bus_err;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, slv_addr, slv_wdata, err_addr;
  logic [3:0]   mem_wstrb, slv_wstrb, slv_valid, slv_ready;
  logic [127:0] slv_rdata;
  logic [7:0]   err_count;

  logic         o_mem_valid, o_mem_ready, o_bus_err;
  logic [31:0]  o_mem_addr, o_mem_wdata, o_mem_rdata, o_slv_addr, o_slv_wdata, o_err_addr;
  logic [3:0]   o_mem_wstrb, o_slv_wstrb, o_slv_valid, o_slv_ready;
  logic [127:0] o_slv_rdata;
  logic [7:0]   o_err_count;

  native_bus_fabric #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slv_valid(slv_valid), .slv_ready(slv_ready), .slv_rdata(slv_rdata),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
  );

  native_bus_fabric #(
    .SLV_BASE({32'h8000_0010, 32'h8000_0008, 32'h8000_0008, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFE_0000})
  ) dut_ovl (
    .clk(clk), .reset(reset),
    .mem_valid(o_mem_valid), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata), .mem_wstrb(o_mem_wstrb),
    .mem_ready(o_mem_ready), .mem_rdata(o_mem_rdata),
    .slv_valid(o_slv_valid), .slv_ready(o_slv_ready), .slv_rdata(o_slv_rdata),
    .slv_addr(o_slv_addr), .slv_wdata(o_slv_wdata), .slv_wstrb(o_slv_wstrb),
    .bus_err(o_bus_err), .err_addr(o_err_addr), .err_count(o_err_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; slv_ready = '0;
    slv_rdata = {32'h3333_3333, 32'hCAFE_0002, 32'h0000_0011, 32'h1234_5678};
    o_mem_valid = 1'b0; o_mem_addr = '0; o_mem_wdata = '0; o_mem_wstrb = '0; o_slv_ready = '0;
    o_slv_rdata = {32'h0000_0303, 32'h0000_0202, 32'h0000_0101, 32'h0000_0000};

    step(); step();
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_slv_valid", 32'(slv_valid), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_bus_err",   32'(bus_err), 32'd0);
    chk("rst_slv_addr",  slv_addr, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    step();

    // SRAM read, ready one cycle after select
    mem_valid = 1'b1; mem_addr = 32'h0000_0100;
    step();
    chk("sram_slv_valid", 32'(slv_valid), 32'h1);
    chk("sram_slv_addr",  slv_addr, 32'h0000_0100);
    chk("sram_early_rdy", 32'(mem_ready), 32'd0);
    slv_ready = 4'b0001;
    step();
    chk("sram_mem_ready", 32'(mem_ready), 32'd1);
    chk("sram_rdata",     mem_rdata, 32'h1234_5678);
    chk("sram_bus_err",   32'(bus_err), 32'd0);
    chk("sram_valid_off", 32'(slv_valid), 32'd0);
    mem_valid = 1'b0; slv_ready = '0;
    step();
    chk("sram_ready_pulse", 32'(mem_ready), 32'd0);

    // LED write, five wait cycles
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wdata = 32'h0000_00A5; mem_wstrb = 4'b0001;
    step();
    chk("led_slv_wdata", slv_wdata, 32'h0000_00A5);
    chk("led_slv_wstrb", 32'(slv_wstrb), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("led_slv_valid", 32'(slv_valid), 32'h2);
      chk("led_no_ready",  32'(mem_ready), 32'd0);
      if (i == 4) slv_ready = 4'b0010;
      else        step();
    end
    step();
    chk("led_mem_ready",  32'(mem_ready), 32'd1);
    chk("led_valid_off",  32'(slv_valid), 32'd0);
    chk("led_bus_err",    32'(bus_err), 32'd0);
    chk("led_rdata",      mem_rdata, 32'h0000_0011);
    mem_valid = 1'b0; mem_wstrb = '0; slv_ready = '0;
    step();
    chk("led_single_pulse", 32'(mem_ready), 32'd0);
    chk("led_addr_hold",    slv_addr, 32'h8000_0000);

    // Unmapped read
    mem_valid = 1'b1; mem_addr = 32'h4000_0000;
    step();
    chk("miss_mem_ready", 32'(mem_ready), 32'd1);
    chk("miss_rdata",     mem_rdata, 32'hDEAD_BEEF);
    chk("miss_bus_err",   32'(bus_err), 32'd1);
    chk("miss_no_valid",  32'(slv_valid), 32'd0);
    chk("miss_err_addr",  err_addr, CAP ? 32'h4000_0000 : 32'd0);
    chk("miss_err_count", 32'(err_count), CAP ? 32'd1 : 32'd0);
    mem_valid = 1'b0;
    step();
    chk("miss_err_pulse", 32'(bus_err), 32'd0);
    chk("miss_rdy_pulse", 32'(mem_ready), 32'd0);

    // UART timeout; other slaves' ready must be ignored
    mem_valid = 1'b1; mem_addr = 32'h8000_000C; slv_ready = 4'b1011;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("to_slv_valid", 32'(slv_valid), 32'h4);
      chk("to_no_ready",  32'(mem_ready), 32'd0);
      step();
    end
    chk("to_valid_off",  32'(slv_valid), 32'd0);
    chk("to_mem_ready",  32'(mem_ready), 32'd1);
    chk("to_rdata",      mem_rdata, 32'hDEAD_BEEF);
    chk("to_bus_err",    32'(bus_err), 32'd1);
    chk("to_err_addr",   err_addr, CAP ? 32'h8000_000C : 32'd0);
    chk("to_err_count",  32'(err_count), CAP ? 32'd2 : 32'd0);
    mem_valid = 1'b0; slv_ready = '0;
    step();
    chk("to_rdy_pulse", 32'(mem_ready), 32'd0);

    // UART ready on the 8th ACCESS cycle beats the timeout
    mem_valid = 1'b1; mem_addr = 32'h8000_000C;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("late_slv_valid", 32'(slv_valid), 32'h4);
      if (i == 7) slv_ready = 4'b0100;
      else        step();
    end
    step();
    chk("late_mem_ready", 32'(mem_ready), 32'd1);
    chk("late_rdata",     mem_rdata, 32'hCAFE_0002);
    chk("late_bus_err",   32'(bus_err), 32'd0);
    chk("late_err_count", 32'(err_count), CAP ? 32'd2 : 32'd0);
    mem_valid = 1'b0; slv_ready = '0;
    step();

    // Overlapping map: slot1 and slot2 both hit, slot1 wins
    o_mem_valid = 1'b1; o_mem_addr = 32'h8000_0008;
    step();
    chk("ovl_slv_valid", 32'(o_slv_valid), 32'h2);
    o_slv_ready = 4'b0010;
    step();
    chk("ovl_mem_ready", 32'(o_mem_ready), 32'd1);
    chk("ovl_rdata",     o_mem_rdata, 32'h0000_0101);
    o_mem_valid = 1'b0; o_slv_ready = '0;
    step();

    // Reset during ACCESS aborts immediately
    mem_valid = 1'b1; mem_addr = 32'h0000_0000;
    step();
    chk("abort_slv_valid", 32'(slv_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid_off", 32'(slv_valid), 32'd0);
    chk("abort_no_ready",  32'(mem_ready), 32'd0);
    chk("abort_err_count", 32'(err_count), 32'd0);
    mem_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("abort_no_resp", 32'(mem_ready), 32'd0);
    mem_valid = 1'b1; mem_addr = 32'h0000_0000;
    step();
    chk("post_slv_valid", 32'(slv_valid), 32'h1);
    slv_ready = 4'b0001;
    step();
    chk("post_mem_ready", 32'(mem_ready), 32'd1);
    chk("post_rdata",     mem_rdata, 32'h1234_5678);
    chk("post_bus_err",   32'(bus_err), 32'd0);
    mem_valid = 1'b0; slv_ready = '0;
    step();
    chk("post_rdy_pulse", 32'(mem_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/native_bus_fabric.md
Name: native_bus_fabric

Overview:
Parametrised single-master, N-slave interconnect for the picorv32 native memory interface, replacing hand-written per-slave select/ready/rdata decode in the SoC top.
- Decodes the address against a per-slave base/mask table and forwards the access to one slave.
- Registers the response and returns it to the core.
- Adds unmapped-address and slave-timeout handling: the core never hangs, and erroneous accesses return a fixed error word.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
SLV_BASE, {32'h8000_0010, 32'h8000_0008, 32'h8000_0000, 32'h0000_0000}, packed NUM_SLAVES*32 base addresses; slot i = bits [32i+31:32i]
SLV_MASK, {32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFE_0000}, packed NUM_SLAVES*32 decode masks
TIMEOUT_CYCLES, 255, number of ACCESS cycles without slave ready before abort (1..65535)
ERR_DATA, 32'hDEAD_BEEF, read data returned on a decode miss or timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  core request valid
mem_addr  in  32  core address
mem_wdata  in  32  core write data
mem_wstrb  in  4  core byte write enables; 0 = read
mem_ready  out  1  response to core, one-cycle pulse
mem_rdata  out  32  registered read data to core
slv_valid  out  NUM_SLAVES  one-hot slave select
slv_ready  in  NUM_SLAVES  per-slave done
slv_rdata  in  NUM_SLAVES*32  packed per-slave read data
slv_addr  out  32  latched address, broadcast to all slaves
slv_wdata  out  32  latched write data, broadcast to all slaves
slv_wstrb  out  4  latched byte enables, broadcast to all slaves
bus_err  out  1  one-cycle pulse on a decode miss or timeout
err_addr  out  32  address of the last error (optional feature)
err_count  out  8  saturating error count (optional feature)

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; timeout counter 0. Asserting reset mid-transaction drops slv_valid and mem_ready at once. No response is ever issued for an aborted transaction.
- Decode: hit[i] = ((mem_addr & MASK_i) == BASE_i). If several slots hit, the lowest index wins.
- FSM states: IDLE, ACCESS, RESP.
- IDLE & mem_valid & any hit:
  - latch mem_addr, mem_wdata, mem_wstrb and the winning index;
  - set slv_valid[idx] = 1;
  - go to ACCESS.
- IDLE & mem_valid & no hit:
  - load mem_rdata = ERR_DATA;
  - pulse bus_err;
  - go to RESP.
- ACCESS:
  - timeout counter increments every cycle.
  - If slv_ready[idx] = 1: capture slv_rdata[idx] into mem_rdata, clear slv_valid, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES: clear slv_valid, mem_rdata = ERR_DATA, pulse bus_err, go to RESP.
  - If ready and timeout fall in the same cycle, ready wins and no error is raised.
  - slv_ready bits of unselected slaves are ignored.
- RESP:
  - mem_ready = 1 for exactly one cycle, with mem_rdata stable;
  - counter cleared;
  - go to IDLE.
- For writes, mem_rdata is still loaded (slave data or ERR_DATA); the core ignores it.
- Latency: mem_valid sampled at edge T → slv_valid high after T → slave ready sampled at edge T+k (k≥1) → mem_ready high in cycle T+k+1. Minimum is 3 cycles from valid to ready.
- mem_valid low in IDLE: no action. The core drops mem_valid after ready, so no duplicate accept occurs.
- slv_addr, slv_wdata and slv_wstrb hold their values from accept until the next accept.

Optional Feature:
BUS_ERR_CAPTURE_EN
- Defined:
  - err_addr latches the erroring address on every bus_err;
  - err_count increments on every bus_err and saturates at 255;
  - both are cleared only by reset.
- Undefined: err_addr and err_count are tied to 0 and no capture registers are built. bus_err is always present.

Test Plan:
- SRAM read at 0x0000_0100 with a slave that is ready 1 cycle after select and returns 0x1234_5678 → slv_valid=4'b0001; mem_ready in cycle T+2; mem_rdata=0x1234_5678; bus_err=0.
- Write of 0x0000_00A5, wstrb 4'b0001, to 0x8000_0000, with LED slave ready after 5 wait cycles → slv_valid=4'b0010 held for 5 cycles; slv_wdata=0xA5; single mem_ready pulse.
- Read of unmapped 0x4000_0000 → no slv_valid; mem_ready at T+1; mem_rdata=0xDEAD_BEEF; bus_err pulse; with the feature, err_addr=0x4000_0000 and err_count=1.
- UART 0x8000_000C with slave never ready, TIMEOUT_CYCLES=8 → slv_valid dropped after 8 ACCESS cycles; mem_rdata=0xDEAD_BEEF; bus_err pulse. Repeat with ready arriving on the 8th cycle → data returned and no bus_err.
- Overlapping map, slot1 = slot2 = 0x8000_0008 → only slv_valid[1] asserts.
- Reset asserted during ACCESS → slv_valid and mem_ready go 0 immediately. After release, a new read to 0x0 completes normally; with the feature, err_count resets to 0.
